// File: rtl/osd_pkg.sv
// Shared definitions for the OSD candidate selector.
//   state_t      : selector FSM states
//   cost_width() : width of an accumulated candidate cost
//   slice_lsb()  : LSB of a packed row/slot in the flat operand buses
//   DEF_*        : default code dimensions
//   DRAIN_*      : pipeline drain length after the last mask
package osd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_K = 8;
  localparam int unsigned DEF_M = 8;
  localparam int unsigned DEF_W = 6;

  // Two pipeline stages must empty before the final best_* is valid.
  localparam int unsigned       DRAIN_CYCLES = 2;
  localparam int unsigned       DRAIN_W      = $clog2(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(DRAIN_CYCLES - 1);

  // Worst case sums K+M values of W bits each.
  function automatic int unsigned cost_width(int unsigned w, int unsigned k, int unsigned m);
    return w + $clog2(k + m + 1);
  endfunction

  // Row r of p_matrix / slot r of rel_* starts at bit r*width.
  function automatic int unsigned slice_lsb(int unsigned idx, int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/osd_cost_adder.sv
// Masked reliability sum with registered output.
//   clk  : rising-edge clock
//   vals : L packed W-bit values, slot i at [i*W +: W]
//   mask : selects which slots are added
//   base : value the selected slots are added onto
//   sum  : registered base + sum of selected slots (OW bits, sized to never overflow)
module osd_cost_adder
  import osd_pkg::*;
#(
  parameter int unsigned L  = 8,
  parameter int unsigned W  = 6,
  parameter int unsigned OW = 11
) (
  input  logic            clk,
  input  logic [L*W-1:0]  vals,
  input  logic [L-1:0]    mask,
  input  logic [OW-1:0]   base,
  output logic [OW-1:0]   sum
);

  logic [OW-1:0] acc;

  always_comb begin
    acc = base;
    for (int unsigned i = 0; i < L; i++) begin
      if (mask[i]) begin
        acc = acc + OW'(vals[slice_lsb(i, W) +: W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    sum <= acc;
  end

endmodule

// File: rtl/osd_candidate_selector.sv
// Ordered-statistics decoding candidate selector.
// Evaluates a stream of MRB flip masks against latched operands and keeps the
// lowest-cost candidate (order-0 candidate included, ties keep the earlier one).
//   clk, rst           : clock, synchronous active-high reset
//   start              : pulse in IDLE latches operands and begins a decode
//   par_diff0          : order-0 parity discrepancy (M bits)
//   p_matrix           : K parity rows, row r at [r*M +: M]
//   rel_info, rel_par  : W-bit reliabilities, slot r at [r*W +: W]
//   mask_valid/ready   : mask stream handshake; flip_mask, mask_last payload
//   best_mask/best_cost: best candidate so far, stable after done
//   done               : one-cycle completion pulse
// An upstream mask generator hooks up with en = mask_valid & mask_ready and
// drives mask_last from its own done condition.
module osd_candidate_selector
  import osd_pkg::*;
#(
  parameter  int unsigned K  = DEF_K,
  parameter  int unsigned M  = DEF_M,
  parameter  int unsigned W  = DEF_W,
  localparam int unsigned CW = cost_width(W, K, M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M-1:0]   par_diff0,
  input  logic [K*M-1:0] p_matrix,
  input  logic [K*W-1:0] rel_info,
  input  logic [M*W-1:0] rel_par,
  input  logic           mask_valid,
  output logic           mask_ready,
  input  logic [K-1:0]   flip_mask,
  input  logic           mask_last,
  output logic [K-1:0]   best_mask,
  output logic [CW-1:0]  best_cost,
  output logic           done
);

  state_t               state, state_next;
  logic [DRAIN_W-1:0]   drain_cnt;

  logic [M-1:0]         par_diff0_q;
  logic [K*M-1:0]       p_matrix_q;
  logic [K*W-1:0]       rel_info_q;
  logic [M*W-1:0]       rel_par_q;

  logic                 accept_start, xfer;
  logic                 s0_valid;
  logic [K-1:0]         s0_mask;
  logic [M-1:0]         s0_par_diff;

  logic                 s1_valid, s2_valid;
  logic [K-1:0]         s1_mask, s2_mask;
  logic [M-1:0]         s1_par_diff;
  logic [CW-1:0]        s1_info_cost, s2_cost;
  logic                 have_best;

  // FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    mask_ready = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_EVAL;
      ST_EVAL: begin
        mask_ready = 1'b1;
        if (mask_valid && mask_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  assign accept_start = (state == ST_IDLE) && start;
  assign xfer         = mask_valid && mask_ready;

  // Operand capture
  always_ff @(posedge clk) begin
    if (accept_start) begin
      par_diff0_q <= par_diff0;
      p_matrix_q  <= p_matrix;
      rel_info_q  <= rel_info;
      rel_par_q   <= rel_par;
    end
  end

  // Stage-1 input. The order-0 candidate enters on the start cycle, before the
  // operand registers load: its mask is zero, so only par_diff0 needs the
  // bypass; the stale p_matrix_q/rel_info_q rows are all masked out.
  always_comb begin
    s0_valid    = accept_start || xfer;
    s0_mask     = accept_start ? '0 : flip_mask;
    s0_par_diff = accept_start ? par_diff0 : par_diff0_q;
    for (int unsigned r = 0; r < K; r++) begin
      if (s0_mask[r]) begin
        s0_par_diff = s0_par_diff ^ p_matrix_q[slice_lsb(r, M) +: M];
      end
    end
  end

  osd_cost_adder #(
    .L (K),
    .W (W),
    .OW(CW)
  ) u_info_adder (
    .clk (clk),
    .vals(rel_info_q),
    .mask(s0_mask),
    .base('0),
    .sum (s1_info_cost)
  );

  // Stage 2 adds the parity cost onto the stage-1 info cost.
  osd_cost_adder #(
    .L (M),
    .W (W),
    .OW(CW)
  ) u_par_adder (
    .clk (clk),
    .vals(rel_par_q),
    .mask(s1_par_diff),
    .base(s1_info_cost),
    .sum (s2_cost)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    s1_mask     <= s0_mask;
    s1_par_diff <= s0_par_diff;
    s2_mask     <= s1_mask;
  end

  // Best tracking. The pipeline is always empty in IDLE, so a start never
  // coincides with a stage-2 result.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_mask <= '0;
      best_cost <= '1;
      have_best <= 1'b0;
    end else if (accept_start) begin
      have_best <= 1'b0;
    end else if (s2_valid) begin
      have_best <= 1'b1;
      if (!have_best || (s2_cost < best_cost)) begin
        best_mask <= s2_mask;
        best_cost <= s2_cost;
      end
    end
  end

endmodule

// File: tb/tb_osd_candidate_selector.sv
// Scoreboard bench for osd_candidate_selector (K=M=8, W=6).
module tb_osd_candidate_selector;

  localparam int unsigned K  = 8;
  localparam int unsigned M  = 8;
  localparam int unsigned W  = 6;
  localparam int unsigned CW = W + $clog2(K + M + 1);

  logic           clk = 1'b0;
  logic           rst, start, mask_valid, mask_last;
  logic [M-1:0]   par_diff0;
  logic [K*M-1:0] p_matrix;
  logic [K*W-1:0] rel_info;
  logic [M*W-1:0] rel_par;
  logic [K-1:0]   flip_mask;
  logic           mask_ready, done;
  logic [K-1:0]   best_mask;
  logic [CW-1:0]  best_cost;

  always #5 clk = ~clk;

  osd_candidate_selector #(.K(K), .M(M), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .par_diff0 (par_diff0),
    .p_matrix  (p_matrix),
    .rel_info  (rel_info),
    .rel_par   (rel_par),
    .mask_valid(mask_valid),
    .mask_ready(mask_ready),
    .flip_mask (flip_mask),
    .mask_last (mask_last),
    .best_mask (best_mask),
    .best_cost (best_cost),
    .done      (done)
  );

  typedef struct packed {
    logic [K-1:0]  mask;
    logic [CW-1:0] cost;
  } result_t;

  result_t     exp_q[$];
  result_t     mon_r;
  result_t     last_exp;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned done_count  = 0;

  // Operand model
  logic [M-1:0] pd0;
  logic [M-1:0] pm[K];
  logic [W-1:0] ri[K];
  logic [W-1:0] rp[M];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [CW-1:0] model_cost(input logic [K-1:0] m);
    logic [M-1:0] pd;
    int unsigned  c;
    pd = pd0;
    c  = 0;
    for (int r = 0; r < K; r++) begin
      if (m[r]) begin
        pd = pd ^ pm[r];
        c  = c + ri[r];
      end
    end
    for (int j = 0; j < M; j++) if (pd[j]) c = c + rp[j];
    return CW'(c);
  endfunction

  task automatic drive_ops();
    par_diff0 = pd0;
    for (int r = 0; r < K; r++) begin
      p_matrix[r*M +: M] = pm[r];
      rel_info[r*W +: W] = ri[r];
    end
    for (int j = 0; j < M; j++) rel_par[j*W +: W] = rp[j];
  endtask

  task automatic push_exp(input logic [K-1:0] m, input logic [CW-1:0] c);
    result_t r;
    r.mask = m;
    r.cost = c;
    exp_q.push_back(r);
    last_exp = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_mask(input logic [K-1:0] m, input logic last);
    bit sent;
    sent       = 1'b0;
    mask_valid = 1'b1;
    flip_mask  = m;
    mask_last  = last;
    for (int n = 0; n < 20 && !sent; n++) begin
      sent = mask_ready;
      tick();
    end
    if (!sent) begin
      vectors++;
      miscompares++;
      $display("FAIL mask_accept: got ready=0 for 20 cycles, expected ready=1");
    end
    mask_valid = 1'b0;
    mask_last  = 1'b0;
  endtask

  // Returns the cycle index (1 = cycle after the last transfer) where done showed.
  task automatic wait_done(output int unsigned cycles);
    cycles = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) break;
      check("ready_low_in_drain", 32'(mask_ready), 32'd0);
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done in 50 cycles, expected done");
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        mon_r = exp_q.pop_front();
        check("best_mask", 32'(best_mask), 32'(mon_r.mask));
        check("best_cost", 32'(best_cost), 32'(mon_r.cost));
        check("ready_in_done", 32'(mask_ready), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic ops_a();
    pd0 = '0;
    for (int r = 0; r < K; r++) begin pm[r] = '0; ri[r] = 6'd1; end
    for (int j = 0; j < M; j++) rp[j] = 6'd1;
  endtask

  task automatic ops_b();
    pd0 = 8'hFF;
    for (int r = 0; r < K; r++) begin pm[r] = '0; ri[r] = 6'd1; end
    pm[0] = 8'hFF;
    ri[0] = 6'd2;
    for (int j = 0; j < M; j++) rp[j] = 6'd5;
  endtask

  initial begin
    int unsigned  lat;
    int unsigned  dc_before;
    logic [K-1:0] bm, m;
    logic [CW-1:0] bc, c;
    logic [M-1:0] rows[K];

    rst = 1'b1; start = 1'b0; mask_valid = 1'b0; mask_last = 1'b0;
    flip_mask = '0; par_diff0 = '0; p_matrix = '0; rel_info = '0; rel_par = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_ready", 32'(mask_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_best_mask", 32'(best_mask), 32'd0);
    check("rst_best_cost", 32'(best_cost), 32'd2047);

    // Single zero mask: order-0 and mask 0 both cost 0
    ops_a(); drive_ops();
    push_exp(8'h00, 11'd0);
    do_start();
    send_mask(8'h00, 1'b1);
    wait_done(lat);
    check("done_latency", 32'(lat), 32'd3);
    check("ready_idle", 32'(mask_ready), 32'd0);

    // Order-0 cost 40, 0x03 cost 3, 0x01 cost 2
    ops_b(); drive_ops();
    push_exp(8'h01, 11'd2);
    do_start();
    send_mask(8'h03, 1'b0);
    send_mask(8'h01, 1'b1);
    wait_done(lat);
    repeat (3) tick();
    check("hold_best_mask", 32'(best_mask), 32'(last_exp.mask));
    check("hold_best_cost", 32'(best_cost), 32'(last_exp.cost));

    // Tie at cost 7: the earlier 0x04 must be kept over 0x20
    pd0 = 8'hFF;
    for (int r = 0; r < K; r++) begin pm[r] = 8'hFF; ri[r] = 6'd9; end
    ri[2] = 6'd7; ri[5] = 6'd7;
    for (int j = 0; j < M; j++) rp[j] = 6'd5;
    drive_ops();
    push_exp(8'h04, 11'd7);
    do_start();
    send_mask(8'h01, 1'b0);
    send_mask(8'h04, 1'b0);
    send_mask(8'h20, 1'b1);
    wait_done(lat);

    // Full weight-2 sweep with valid toggled every other cycle
    rows = '{8'h3C, 8'hA1, 8'h5E, 8'h07, 8'hC8, 8'h93, 8'h6D, 8'hF2};
    pd0 = 8'hA5;
    ri  = '{6'd12, 6'd3, 6'd27, 6'd8, 6'd19, 6'd5, 6'd30, 6'd14};
    rp  = '{6'd9, 6'd22, 6'd4, 6'd17, 6'd11, 6'd2, 6'd25, 6'd6};
    for (int r = 0; r < K; r++) pm[r] = rows[r];
    drive_ops();
    bm = '0;
    bc = model_cost('0);
    for (int i = 0; i < K; i++) begin
      for (int j = i + 1; j < K; j++) begin
        m = '0; m[i] = 1'b1; m[j] = 1'b1;
        c = model_cost(m);
        if (c < bc) begin bc = c; bm = m; end
      end
    end
    push_exp(bm, bc);
    do_start();
    for (int i = 0; i < K; i++) begin
      for (int j = i + 1; j < K; j++) begin
        m = '0; m[i] = 1'b1; m[j] = 1'b1;
        tick();
        send_mask(m, (i == K - 2) && (j == K - 1));
      end
    end
    wait_done(lat);

    // Reset one cycle after start, mid-EVAL
    ops_a(); drive_ops();
    do_start();
    rst = 1'b1; mask_valid = 1'b1; flip_mask = 8'h01;
    tick();
    rst = 1'b0; mask_valid = 1'b0;
    check("midrst_ready", 32'(mask_ready), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_best_cost", 32'(best_cost), 32'd2047);
    check("midrst_best_mask", 32'(best_mask), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    tick();
    ops_b(); drive_ops();
    push_exp(8'h01, 11'd2);
    do_start();
    send_mask(8'h03, 1'b0);
    send_mask(8'h01, 1'b1);
    wait_done(lat);
    check("post_rst_latency", 32'(lat), 32'd3);

    // Start pulses during EVAL and DRAIN with different operands are ignored
    ops_b(); drive_ops();
    push_exp(8'h01, 11'd2);
    dc_before = done_count;
    do_start();
    ops_a(); drive_ops();
    do_start();
    send_mask(8'h03, 1'b0);
    send_mask(8'h01, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    repeat (6) tick();
    check("single_done", done_count - dc_before, 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/osd_candidate_selector.md
OSD_CANDIDATE_SELECTOR -- requirements
Module: osd_candidate_selector

Interface
REQ-001 Parameters SHALL be: K, default 8, number of info (MRB) bits; M, default 8, number of parity bits (N-K); W, default 6, reliability magnitude width.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; latches the operands and begins a decode.
REQ-005 par_diff0  in  M  order-0 parity discrepancy (re-encoded MRB parity XOR hard-decision parity).
REQ-006 p_matrix  in  K*M  systematic parity rows; row r is bits [r*M +: M].
REQ-007 rel_info  in  K*W  info reliabilities, slot r is bits [r*W +: W]; rel_par  in  M*W  parity reliabilities, same packing.
REQ-008 mask_valid  in  1 / mask_ready  out  1 / flip_mask  in  K / mask_last  in  1: mask stream; transfer when valid and ready are both high.
REQ-009 best_mask  out  K; best_cost  out  CW = W+$clog2(K+M+1); done  out  1, one-cycle pulse.

Function
REQ-010 FSM states SHALL be IDLE, EVAL, DRAIN, DONE; reset state IDLE.
REQ-011 IDLE: start=1 SHALL capture par_diff0, p_matrix, rel_info, rel_par, inject mask 0 (order-0 candidate) into stage 1 and go to EVAL; start in any other state SHALL be ignored.
REQ-012 mask_ready SHALL equal (state==EVAL); combinational from state only.
REQ-013 EVAL: each transfer SHALL enter stage 1; a transfer with mask_last=1 SHALL move FSM to DRAIN; mask_valid low SHALL stall indefinitely with no side effects.
REQ-014 Stage 1 (registered) SHALL compute info_cost = sum of rel_info[r] over set mask bits and par_diff = par_diff0 XOR (XOR of p_matrix rows r with mask bit r set).
REQ-015 Stage 2 (registered) SHALL compute cost = info_cost + sum of rel_par[c] over set par_diff bits, width CW, no overflow possible.
REQ-016 Compare at stage-2 output: the first candidate of a decode SHALL load best unconditionally; later ones SHALL replace best only if cost < best_cost (strict; ties keep earlier).
REQ-017 Latency: a mask transferred in cycle t SHALL affect best_* at end of cycle t+2.
REQ-018 DRAIN SHALL last exactly 2 cycles, then DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-019 best_mask/best_cost SHALL hold stable from DONE until the next start; flip_mask bits outside any weight restriction are accepted unchanged (weight not checked).
REQ-020 Simultaneous mask_valid with state!=EVAL SHALL be ignored (ready low).

Reset
REQ-021 rst SHALL force state IDLE, mask_ready 0, done 0, best_mask 0, best_cost all-ones, pipeline valid flags 0, overriding any activity including mid-decode.
REQ-022 First start after reset SHALL behave identically to any later start.

Structure
REQ-023 Package osd_pkg SHALL hold the FSM state enum, the CW width function, and the row/slot slicing constants.
REQ-024 Sub-module osd_cost_adder (masked sum of L W-bit values, registered output) SHALL be instantiated twice (K-wide info, M-wide parity).
REQ-025 Upstream 2-bit mask generator connects as: its en = mask_valid & mask_ready, mask_last driven from its done-condition.

Verification
REQ-026 K=M=8, par_diff0=0, all rel=1, single mask 0x00 with last -> done 3 cycles after transfer, best_mask=0x00, best_cost=0.
REQ-027 par_diff0=0xFF, rel_par all 5, p_matrix row0=0xFF, masks 0x03 then 0x01(last), rel_info[0]=2 -> best_mask=0x01, best_cost=2.
REQ-028 Full 28-mask 2-bit sweep with mask_valid toggled every other cycle -> best matches golden model; ready never high outside EVAL.
REQ-029 Two masks with equal cost 7 -> best_mask keeps the earlier one.
REQ-030 rst asserted 1 cycle after start mid-EVAL -> state IDLE, done 0, best_cost all-ones; subsequent start completes normally.
REQ-031 start pulsed during EVAL and DRAIN -> ignored, operands unchanged, single done pulse.
